irr_bank: RTL and testbench

- Parametrised interrupt request register for the next-generation PIC core.
- Synchronises N_IRQ raw request lines and captures them in edge or level mode.
- Resolves the highest-priority unmasked request using a rotating priority base.
- Runs the two-pulse INTA acknowledge handshake itself: freezes the register, latches the selected channel and clears it.

---
 rtl/irr_bank.sv | 140 ++++++++++++++
 tb/tb_irr_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/irr_bank.sv
// Interrupt request register bank: synchronises raw request lines, captures them
// in edge or level mode, resolves a rotating-priority winner and runs the INTA handshake.
module irr_bank #(
  parameter  int N_IRQ       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int IDX_W       = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             ltim,
  input  logic [N_IRQ-1:0] imr,
  input  logic [IDX_W-1:0] prio_base,
  input  logic             inta_1,
  input  logic             inta_2,
  input  logic [N_IRQ-1:0] irr_clr,
  output logic [N_IRQ-1:0] irr_q,
  output logic             int_req,
  output logic [IDX_W-1:0] int_idx,
  output logic             frozen,
  output logic             ack_valid,
  output logic [IDX_W-1:0] ack_idx,
  output logic             ack_spurious,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FROZEN = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_irr;
  logic [N_IRQ-1:0] r_pend;
  state_t           r_state;
  logic [IDX_W-1:0] r_sel;
  logic             r_spur;

  logic [N_IRQ-1:0] w_s;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_cand;
  logic [N_IRQ-1:0] w_irr_set;
  logic [N_IRQ-1:0] w_ack_clr;
  logic [N_IRQ-1:0] w_irr_nxt;
  logic [N_IRQ-1:0] w_pend_nxt;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic             w_frozen;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_sel_nxt;
  logic             w_spur_nxt;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;
  assign w_cand = r_irr & ~imr;

  // Scan from prio_base upward; the index width wraps naturally since N_IRQ is a power of two.
  always_comb begin
    logic [IDX_W-1:0] k;
    w_found = 1'b0;
    w_idx   = '0;
    k       = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      k = prio_base + IDX_W'(i);
      if (!w_found && w_cand[k]) begin
        w_found = 1'b1;
        w_idx   = k;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_spur_nxt  = r_spur;
    case (r_state)
      S_IDLE: begin
        if (inta_1) begin
          w_state_nxt = S_FROZEN;
          w_sel_nxt   = w_found ? w_idx : IDX_W'(N_IRQ - 1);
          w_spur_nxt  = ~w_found;
        end
      end
      S_FROZEN: begin
        if (irr_clr[r_sel]) w_spur_nxt = 1'b1;
        if (inta_2)         w_state_nxt = S_ACK;
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // While frozen the register holds; edges are parked in pend and merged once released.
  always_comb begin
    w_frozen  = (r_state == S_FROZEN);
    w_ack_clr = '0;
    if (w_frozen)  w_irr_set = r_irr;
    else if (ltim) w_irr_set = w_s;
    else           w_irr_set = r_irr | w_rise | r_pend;
    if (r_state == S_ACK && !r_spur) w_ack_clr[r_sel] = 1'b1;
    w_irr_nxt = w_irr_set & ~w_ack_clr & ~irr_clr;
    if (w_frozen && !ltim) w_pend_nxt = r_pend | w_rise;
    else if (w_frozen)     w_pend_nxt = r_pend;
    else                   w_pend_nxt = '0;
    w_pend_nxt = w_pend_nxt & ~irr_clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev  <= '0;
      r_irr   <= '0;
      r_pend  <= '0;
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_spur  <= 1'b0;
    end else begin
      r_sync[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev  <= w_s;
      r_irr   <= w_irr_nxt;
      r_pend  <= w_pend_nxt;
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_spur  <= w_spur_nxt;
    end
  end

  assign irr_q        = r_irr;
  assign int_req      = w_found;
  assign int_idx      = w_idx;
  assign frozen       = (r_state == S_FROZEN);
  assign ack_valid    = (r_state == S_ACK);
  assign ack_idx      = (r_state == S_ACK) ? r_sel : '0;
  assign ack_spurious = (r_state == S_ACK) ? r_spur : 1'b0;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_irr_bank.sv
// Directed bench for irr_bank: capture latency, level drop-out, rotating priority,
// INTA handshake with freeze merge, spurious acknowledges and async reset abort.
module tb_irr_bank;

  logic       clk;
  logic       reset;
  logic [7:0] irq_in;
  logic       ltim;
  logic [7:0] imr;
  logic [2:0] prio_base;
  logic       inta_1;
  logic       inta_2;
  logic [7:0] irr_clr;
  logic [7:0] irr_q;
  logic       int_req;
  logic [2:0] int_idx;
  logic       frozen;
  logic       ack_valid;
  logic [2:0] ack_idx;
  logic       ack_spurious;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  irr_bank #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .ltim(ltim), .imr(imr),
    .prio_base(prio_base), .inta_1(inta_1), .inta_2(inta_2), .irr_clr(irr_clr),
    .irr_q(irr_q), .int_req(int_req), .int_idx(int_idx), .frozen(frozen),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .ack_spurious(ack_spurious),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (irr_q !== 8'h00) begin bad++; $display("FAIL reset_irr got=%h exp=00", irr_q); end
    total++; if (int_req !== 1'b0 || int_idx !== 3'd0) begin bad++; $display("FAIL reset_int got=%b/%0d exp=0/0", int_req, int_idx); end
    total++; if (frozen !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL reset_fsm got=%b/%0d exp=0/0", frozen, dbg_state); end
    total++; if (ack_valid !== 1'b0 || ack_idx !== 3'd0 || ack_spurious !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b/%0d/%b exp=0/0/0", ack_valid, ack_idx, ack_spurious); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_edge_capture();
    irq_in = 8'h10;
    tick(2);
    total++; if (irr_q !== 8'h00) begin bad++; $display("FAIL edge_early got=%h exp=00", irr_q); end
    tick();
    total++; if (irr_q !== 8'h10) begin bad++; $display("FAIL edge_latency got=%h exp=10", irr_q); end
    total++; if (int_req !== 1'b1 || int_idx !== 3'd4) begin bad++; $display("FAIL edge_resolve got=%b/%0d exp=1/4", int_req, int_idx); end
    irr_clr = 8'h10;
    tick();
    irr_clr = 8'h00;
    tick(4);
    total++; if (irr_q !== 8'h00) begin bad++; $display("FAIL edge_no_recapture got=%h exp=00", irr_q); end
    irq_in = 8'h00;
    tick(3);
  endtask

  task automatic test_level();
    ltim = 1'b1;
    irq_in = 8'h04;
    tick(2);
    total++; if (irr_q !== 8'h00) begin bad++; $display("FAIL level_early got=%h exp=00", irr_q); end
    tick();
    total++; if (irr_q !== 8'h04 || int_req !== 1'b1) begin bad++; $display("FAIL level_set got=%h/%b exp=04/1", irr_q, int_req); end
    tick(2);
    irq_in = 8'h00;
    tick(2);
    total++; if (irr_q !== 8'h04) begin bad++; $display("FAIL level_hold got=%h exp=04", irr_q); end
    tick();
    total++; if (irr_q !== 8'h00 || int_req !== 1'b0) begin bad++; $display("FAIL level_drop got=%h/%b exp=00/0", irr_q, int_req); end
    ltim = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    irq_in = 8'h81;
    tick(3);
    total++; if (irr_q !== 8'h81) begin bad++; $display("FAIL prio_setup got=%h exp=81", irr_q); end
    prio_base = 3'd0; #1;
    total++; if (int_idx !== 3'd0) begin bad++; $display("FAIL prio_base0 got=%0d exp=0", int_idx); end
    prio_base = 3'd5; #1;
    total++; if (int_idx !== 3'd7) begin bad++; $display("FAIL prio_base5 got=%0d exp=7", int_idx); end
    imr = 8'h80; #1;
    total++; if (int_idx !== 3'd0 || int_req !== 1'b1) begin bad++; $display("FAIL prio_masked got=%0d/%b exp=0/1", int_idx, int_req); end
    imr = 8'h81; #1;
    total++; if (int_req !== 1'b0 || int_idx !== 3'd0) begin bad++; $display("FAIL prio_all_masked got=%b/%0d exp=0/0", int_req, int_idx); end
    imr = 8'h00; prio_base = 3'd0;
    irq_in = 8'h00;
    irr_clr = 8'h81;
    tick();
    irr_clr = 8'h00;
    tick(3);
  endtask

  task automatic test_handshake();
    irq_in = 8'h08;
    tick(3);
    inta_1 = 1'b1;
    tick();
    inta_1 = 1'b0;
    total++; if (frozen !== 1'b1 || irr_q !== 8'h08) begin bad++; $display("FAIL hs_freeze got=%b/%h exp=1/08", frozen, irr_q); end
    irq_in = 8'h0A;
    tick(3);
    total++; if (frozen !== 1'b1 || irr_q !== 8'h08) begin bad++; $display("FAIL hs_hold got=%b/%h exp=1/08", frozen, irr_q); end
    inta_2 = 1'b1;
    tick();
    inta_2 = 1'b0;
    total++; if (ack_valid !== 1'b1 || ack_idx !== 3'd3 || ack_spurious !== 1'b0) begin bad++; $display("FAIL hs_ack got=%b/%0d/%b exp=1/3/0", ack_valid, ack_idx, ack_spurious); end
    total++; if (frozen !== 1'b0) begin bad++; $display("FAIL hs_ack_frozen got=%b exp=0", frozen); end
    tick();
    total++; if (irr_q !== 8'h02 || ack_valid !== 1'b0) begin bad++; $display("FAIL hs_merge got=%h/%b exp=02/0", irr_q, ack_valid); end
    irq_in = 8'h00;
    irr_clr = 8'h02;
    tick();
    irr_clr = 8'h00;
    tick(3);
  endtask

  task automatic test_spurious();
    inta_1 = 1'b1;
    tick();
    inta_1 = 1'b0;
    inta_2 = 1'b1;
    tick();
    inta_2 = 1'b0;
    total++; if (ack_valid !== 1'b1 || ack_idx !== 3'd7 || ack_spurious !== 1'b1) begin bad++; $display("FAIL spur_a got=%b/%0d/%b exp=1/7/1", ack_valid, ack_idx, ack_spurious); end
    tick();
    total++; if (irr_q !== 8'h00) begin bad++; $display("FAIL spur_a_irr got=%h exp=00", irr_q); end
    irq_in = 8'h08;
    tick(3);
    inta_1 = 1'b1;
    tick();
    inta_1 = 1'b0;
    irr_clr = 8'h08;
    tick();
    irr_clr = 8'h00;
    total++; if (irr_q !== 8'h00 || frozen !== 1'b1) begin bad++; $display("FAIL spur_b_clr got=%h/%b exp=00/1", irr_q, frozen); end
    inta_2 = 1'b1;
    tick();
    inta_2 = 1'b0;
    total++; if (ack_valid !== 1'b1 || ack_idx !== 3'd3 || ack_spurious !== 1'b1) begin bad++; $display("FAIL spur_b got=%b/%0d/%b exp=1/3/1", ack_valid, ack_idx, ack_spurious); end
    irq_in = 8'h00;
    tick(3);
  endtask

  task automatic test_back_to_back();
    inta_1 = 1'b1;
    inta_2 = 1'b1;
    tick();
    inta_1 = 1'b0;
    inta_2 = 1'b0;
    total++; if (frozen !== 1'b1 || ack_valid !== 1'b0) begin bad++; $display("FAIL both_inta got=%b/%b exp=1/0", frozen, ack_valid); end
    inta_1 = 1'b1;
    tick();
    inta_1 = 1'b0;
    total++; if (frozen !== 1'b1) begin bad++; $display("FAIL repeat_inta1 got=%b exp=1", frozen); end
    inta_2 = 1'b1;
    tick();
    inta_2 = 1'b0;
    total++; if (ack_valid !== 1'b1 || ack_idx !== 3'd7 || ack_spurious !== 1'b1) begin bad++; $display("FAIL both_inta_ack got=%b/%0d/%b exp=1/7/1", ack_valid, ack_idx, ack_spurious); end
    tick();
  endtask

  task automatic test_reset_mid();
    irq_in = 8'h20;
    tick(3);
    inta_1 = 1'b1;
    tick();
    inta_1 = 1'b0;
    irq_in = 8'h21;
    tick(3);
    total++; if (frozen !== 1'b1 || irr_q !== 8'h20) begin bad++; $display("FAIL rst_mid_pre got=%b/%h exp=1/20", frozen, irr_q); end
    irq_in = 8'h00;
    #2;
    reset = 1'b1;
    #1;
    total++; if (irr_q !== 8'h00 || frozen !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL rst_mid_async got=%h/%b/%0d exp=00/0/0", irr_q, frozen, dbg_state); end
    @(negedge clk);
    reset = 1'b0;
    inta_2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (ack_valid !== 1'b0 || frozen !== 1'b0 || irr_q !== 8'h00) begin bad++; $display("FAIL rst_mid_after%0d got=%b/%b/%h exp=0/0/00", i, ack_valid, frozen, irr_q); end
    end
    inta_2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    irq_in = 8'h00; ltim = 1'b0; imr = 8'h00; prio_base = 3'd0;
    inta_1 = 1'b0; inta_2 = 1'b0; irr_clr = 8'h00;
    test_reset();
    test_edge_capture();
    test_level();
    test_priority();
    test_handshake();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
